// File: rtl/mips_pkg.sv
// Shared constants and types for the HI/LO unit: select encoding and FSM states.
package mips_pkg;

    localparam int HI_LO_SEL_WIDTH = 2;

    localparam logic [HI_LO_SEL_WIDTH-1:0] HL_HOLD = 2'b00;
    localparam logic [HI_LO_SEL_WIDTH-1:0] HL_RS   = 2'b01;
    localparam logic [HI_LO_SEL_WIDTH-1:0] HL_DIV  = 2'b10;
    localparam logic [HI_LO_SEL_WIDTH-1:0] HL_MULT = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DIVIDE = 2'b01,
        FIXUP  = 2'b10
    } hilo_state_t;

endpackage

// File: rtl/mips_div_iter.sv
// Unsigned restoring divider, one shift-subtract step per cycle, W steps.
// A start pulse while idle loads the operands; busy is high for the W step
// cycles, last flags the final step cycle, and done pulses for one cycle
// once quotient/remainder are final.
module mips_div_iter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         last,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(W - 1);

    logic [W-1:0]     rem_r;
    logic [W-1:0]     quo_r;
    logic [W-1:0]     dvs_r;
    logic [CNT_W-1:0] cnt_r;
    logic             run_r;
    logic             done_r;

    logic [W:0]   shifted_s;
    logic [W:0]   diff_s;
    logic [W-1:0] rem_nx_s;
    logic [W-1:0] quo_nx_s;

    // One restoring step: shift in the next dividend bit, keep the difference if non-negative.
    always_comb begin
        shifted_s = {rem_r, quo_r[W-1]};
        diff_s    = shifted_s - {1'b0, dvs_r};
        rem_nx_s  = rem_r;
        quo_nx_s  = quo_r;
        if (diff_s[W] == 1'b0) begin
            rem_nx_s = diff_s[W-1:0];
            quo_nx_s = {quo_r[W-2:0], 1'b1};
        end else begin
            rem_nx_s = shifted_s[W-1:0];
            quo_nx_s = {quo_r[W-2:0], 1'b0};
        end
    end

    // Operand load on start, then iterate until the step counter reaches its last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_r  <= '0;
            quo_r  <= '0;
            dvs_r  <= '0;
            cnt_r  <= '0;
            run_r  <= 1'b0;
            done_r <= 1'b0;
        end else if (start && !run_r) begin
            rem_r  <= '0;
            quo_r  <= dividend;
            dvs_r  <= divisor;
            cnt_r  <= '0;
            run_r  <= 1'b1;
            done_r <= 1'b0;
        end else if (run_r) begin
            rem_r <= rem_nx_s;
            quo_r <= quo_nx_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == LAST_C) begin
                run_r  <= 1'b0;
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy      = run_r;
    assign last      = run_r && (cnt_r == LAST_C);
    assign done      = done_r;
    assign quotient  = quo_r;
    assign remainder = rem_r;

endmodule

// File: rtl/mips_hilo_unit.sv
// HI/LO register pair with single-cycle MULT, MTHI/MTLO and a 34-cycle signed DIV.
// Signs are stripped before the unsigned divider and re-applied in FIXUP;
// divide-by-zero and the INT_MIN/-1 overflow are overridden in FIXUP.
module mips_hilo_unit
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       hi_write,
    input  logic                       lo_write,
    input  logic [HI_LO_SEL_WIDTH-1:0] hi_select,
    input  logic [HI_LO_SEL_WIDTH-1:0] lo_select,
    input  logic [DATA_WIDTH-1:0]      rs_val,
    input  logic [DATA_WIDTH-1:0]      rt_val,
    output logic [DATA_WIDTH-1:0]      hi_out,
    output logic [DATA_WIDTH-1:0]      lo_out,
    output logic                       busy
);

    localparam logic [DATA_WIDTH-1:0] MIN_NEG_C = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ALL_ONE_C = {DATA_WIDTH{1'b1}};

    // Unsigned magnitude; the most negative value maps to itself, which is correct unsigned.
    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] m;
        if (v[DATA_WIDTH-1]) begin
            m = '0 - v;
        end else begin
            m = v;
        end
        return m;
    endfunction

    hilo_state_t           state_r;
    hilo_state_t           state_nx_s;
    logic [DATA_WIDTH-1:0] hi_r;
    logic [DATA_WIDTH-1:0] lo_r;
    logic [DATA_WIDTH-1:0] hi_nx_s;
    logic [DATA_WIDTH-1:0] lo_nx_s;
    logic                  busy_r;

    logic [DATA_WIDTH-1:0] dividend_r;
    logic                  dvd_neg_r;
    logic                  quo_neg_r;
    logic                  div_zero_r;
    logic                  div_ovf_r;

    logic mult_cmd_s;
    logic div_cmd_s;
    logic mthi_cmd_s;
    logic mtlo_cmd_s;
    logic div_start_s;

    logic [2*DATA_WIDTH-1:0] rs_ext_s;
    logic [2*DATA_WIDTH-1:0] rt_ext_s;
    logic [2*DATA_WIDTH-1:0] product_s;

    logic                  div_busy_s;
    logic                  div_last_s;
    logic                  div_done_s;
    logic [DATA_WIDTH-1:0] div_quo_s;
    logic [DATA_WIDTH-1:0] div_rem_s;
    logic [DATA_WIDTH-1:0] fix_hi_s;
    logic [DATA_WIDTH-1:0] fix_lo_s;

    assign mult_cmd_s = hi_write && lo_write && (hi_select == HL_MULT) && (lo_select == HL_MULT);
    assign div_cmd_s  = hi_write && lo_write && (hi_select == HL_DIV)  && (lo_select == HL_DIV);
    assign mthi_cmd_s = hi_write && (hi_select == HL_RS);
    assign mtlo_cmd_s = lo_write && (lo_select == HL_RS);

    // Low 2W bits of the product of sign-extended operands give the signed product.
    assign rs_ext_s  = {{DATA_WIDTH{rs_val[DATA_WIDTH-1]}}, rs_val};
    assign rt_ext_s  = {{DATA_WIDTH{rt_val[DATA_WIDTH-1]}}, rt_val};
    assign product_s = rs_ext_s * rt_ext_s;

    mips_div_iter #(.W(DATA_WIDTH)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start_s),
        .dividend  (magnitude(rs_val)),
        .divisor   (magnitude(rt_val)),
        .busy      (div_busy_s),
        .last      (div_last_s),
        .done      (div_done_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    // Next-state logic; commands are only decoded in IDLE.
    always_comb begin
        state_nx_s  = state_r;
        div_start_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (div_cmd_s) begin
                    state_nx_s  = DIVIDE;
                    div_start_s = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            DIVIDE: begin
                if (div_last_s) begin
                    state_nx_s = FIXUP;
                end else if (div_busy_s) begin
                    state_nx_s = DIVIDE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            FIXUP: begin
                if (div_done_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Apply signs to the unsigned result and override the two special cases.
    always_comb begin
        fix_hi_s = div_rem_s;
        fix_lo_s = div_quo_s;
        if (div_zero_r) begin
            fix_hi_s = dividend_r;
            fix_lo_s = ALL_ONE_C;
        end else if (div_ovf_r) begin
            fix_hi_s = '0;
            fix_lo_s = MIN_NEG_C;
        end else begin
            if (dvd_neg_r) begin
                fix_hi_s = '0 - div_rem_s;
            end else begin
                fix_hi_s = div_rem_s;
            end
            if (quo_neg_r) begin
                fix_lo_s = '0 - div_quo_s;
            end else begin
                fix_lo_s = div_quo_s;
            end
        end
    end

    // HI/LO update selection: MULT or MT* in IDLE, DIV result in FIXUP, hold otherwise.
    always_comb begin
        hi_nx_s = hi_r;
        lo_nx_s = lo_r;
        if (state_r == IDLE) begin
            if (mult_cmd_s) begin
                hi_nx_s = product_s[2*DATA_WIDTH-1:DATA_WIDTH];
                lo_nx_s = product_s[DATA_WIDTH-1:0];
            end else begin
                if (mthi_cmd_s) begin
                    hi_nx_s = rs_val;
                end else begin
                    hi_nx_s = hi_r;
                end
                if (mtlo_cmd_s) begin
                    lo_nx_s = rs_val;
                end else begin
                    lo_nx_s = lo_r;
                end
            end
        end else if (state_r == FIXUP) begin
            hi_nx_s = fix_hi_s;
            lo_nx_s = fix_lo_s;
        end else begin
            hi_nx_s = hi_r;
            lo_nx_s = lo_r;
        end
    end

    // State, HI/LO, busy and the operand sign/special-case flags latched at DIV start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            hi_r       <= '0;
            lo_r       <= '0;
            busy_r     <= 1'b0;
            dividend_r <= '0;
            dvd_neg_r  <= 1'b0;
            quo_neg_r  <= 1'b0;
            div_zero_r <= 1'b0;
            div_ovf_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            hi_r    <= hi_nx_s;
            lo_r    <= lo_nx_s;
            busy_r  <= (state_nx_s != IDLE);
            if (div_start_s) begin
                dividend_r <= rs_val;
                dvd_neg_r  <= rs_val[DATA_WIDTH-1];
                quo_neg_r  <= rs_val[DATA_WIDTH-1] ^ rt_val[DATA_WIDTH-1];
                div_zero_r <= (rt_val == '0);
                div_ovf_r  <= (rs_val == MIN_NEG_C) && (rt_val == ALL_ONE_C);
            end
        end
    end

    assign hi_out = hi_r;
    assign lo_out = lo_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_mips_hilo_unit.sv
// Self-checking bench for mips_hilo_unit: directed vector table, hand-written
// busy/reset sequences, and random commands against a plain-arithmetic model.
module tb_mips_hilo_unit;

    logic        clk;
    logic        rst_n;
    logic        hi_write;
    logic        lo_write;
    logic [1:0]  hi_select;
    logic [1:0]  lo_select;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;

    int vec_count;
    int err_count;

    logic [31:0] hi_m;
    logic [31:0] lo_m;

    typedef struct {
        string       name;
        logic        hw;
        logic        lw;
        logic [1:0]  hs;
        logic [1:0]  ls;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_busy;
    } vec_t;

    vec_t vecs [11];

    mips_hilo_unit #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hi_write  (hi_write),
        .lo_write  (lo_write),
        .hi_select (hi_select),
        .lo_select (lo_select),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .busy      (busy)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model at the instruction level: returns new HI/LO and the stall length.
    task automatic model(input logic hw, input logic lw, input logic [1:0] hs, input logic [1:0] ls,
                         input logic [31:0] rs, input logic [31:0] rt, output int nbusy);
        longint a;
        longint b;
        longint p;
        longint q;
        longint r;
        a = longint'($signed(rs));
        b = longint'($signed(rt));
        nbusy = 0;
        if (hw && lw && hs == 2'b11 && ls == 2'b11) begin
            p = a * b;
            hi_m = p[63:32];
            lo_m = p[31:0];
        end else if (hw && lw && hs == 2'b10 && ls == 2'b10) begin
            nbusy = 33;
            if (b == 0) begin
                hi_m = rs;
                lo_m = 32'hFFFF_FFFF;
            end else begin
                q = a / b;
                r = a % b;
                hi_m = r[31:0];
                lo_m = q[31:0];
            end
        end else begin
            if (hw && hs == 2'b01) hi_m = rs;
            if (lw && ls == 2'b01) lo_m = rs;
        end
    endtask

    // Present one command for one edge starting at a negedge, then time the stall and check results.
    task automatic run_op(input string name, input logic hw, input logic lw,
                          input logic [1:0] hs, input logic [1:0] ls,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] eh, input logic [31:0] el, input int eb);
        int nb;
        hi_write  = hw;
        lo_write  = lw;
        hi_select = hs;
        lo_select = ls;
        rs_val    = rs;
        rt_val    = rt;
        @(posedge clk);
        @(negedge clk);
        hi_write  = 1'b0;
        lo_write  = 1'b0;
        hi_select = 2'b00;
        lo_select = 2'b00;
        nb = 0;
        while (busy && nb < 100) begin
            nb++;
            @(negedge clk);
        end
        check({name, " busy cycles"}, 64'(nb), 64'(eb));
        check({name, " hi"}, {32'd0, hi_out}, {32'd0, eh});
        check({name, " lo"}, {32'd0, lo_out}, {32'd0, el});
    endtask

    initial begin
        int nb;
        int bad;
        vec_count = 0;
        err_count = 0;
        rst_n     = 1'b0;
        hi_write  = 1'b0;
        lo_write  = 1'b0;
        hi_select = 2'b00;
        lo_select = 2'b00;
        rs_val    = 32'd0;
        rt_val    = 32'd0;

        vecs[0]  = '{"mult ffffffff*2",   1'b1, 1'b1, 2'b11, 2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0};
        vecs[1]  = '{"div 100/7",         1'b1, 1'b1, 2'b10, 2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        33};
        vecs[2]  = '{"div -7/2",          1'b1, 1'b1, 2'b10, 2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vecs[3]  = '{"div 5/0",           1'b1, 1'b1, 2'b10, 2'b10, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 33};
        vecs[4]  = '{"div min/-1",        1'b1, 1'b1, 2'b10, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33};
        vecs[5]  = '{"mult min*min",      1'b1, 1'b1, 2'b11, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         0};
        vecs[6]  = '{"noop 10/11 pair",   1'b1, 1'b1, 2'b10, 2'b11, 32'd9,         32'd3,         32'h4000_0000, 32'd0,         0};
        vecs[7]  = '{"noop lone 10",      1'b1, 1'b0, 2'b10, 2'b00, 32'd9,         32'd3,         32'h4000_0000, 32'd0,         0};
        vecs[8]  = '{"div 7/-2",          1'b1, 1'b1, 2'b10, 2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};
        vecs[9]  = '{"mtlo only",         1'b0, 1'b1, 2'b00, 2'b01, 32'hDEAD_BEEF, 32'd0,         32'd1,         32'hDEAD_BEEF, 0};
        vecs[10] = '{"div -100/-7",       1'b1, 1'b1, 2'b10, 2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14,        33};

        // Reset values.
        repeat (3) @(negedge clk);
        check("reset hi", {32'd0, hi_out}, 64'd0);
        check("reset lo", {32'd0, lo_out}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // MTHI and MTLO in the same cycle.
        run_op("mthi+mtlo", 1'b1, 1'b1, 2'b01, 2'b01, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'h0000_1234, 0);
        run_op("mthi 1234", 1'b1, 1'b0, 2'b01, 2'b00, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'h0000_1234, 0);
        run_op("mtlo abcd", 1'b0, 1'b1, 2'b00, 2'b01, 32'h0000_ABCD, 32'd0, 32'h0000_1234, 32'h0000_ABCD, 0);

        // Directed vector table.
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].name, vecs[i].hw, vecs[i].lw, vecs[i].hs, vecs[i].ls, vecs[i].rs, vecs[i].rt,
                   vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_busy);
        end

        // MTHI presented mid-division is ignored.
        hi_write = 1'b1; lo_write = 1'b1; hi_select = 2'b10; lo_select = 2'b10;
        rs_val = 32'd100; rt_val = 32'd7;
        @(posedge clk);
        @(negedge clk);
        lo_write = 1'b0; hi_select = 2'b01; lo_select = 2'b00; rs_val = 32'h55;
        nb = 1;
        repeat (5) begin
            @(negedge clk);
            if (busy) nb++;
        end
        hi_write = 1'b0; hi_select = 2'b00;
        @(negedge clk);
        while (busy && nb < 100) begin
            nb++;
            @(negedge clk);
        end
        check("mid-div mthi busy cycles", 64'(nb), 64'd33);
        check("mid-div mthi hi", {32'd0, hi_out}, 64'd2);
        check("mid-div mthi lo", {32'd0, lo_out}, 64'd14);

        // Reset at division step 10 discards the division.
        run_op("preload", 1'b1, 1'b1, 2'b01, 2'b01, 32'h77, 32'd0, 32'h77, 32'h77, 0);
        hi_write = 1'b1; lo_write = 1'b1; hi_select = 2'b10; lo_select = 2'b10;
        rs_val = 32'd100; rt_val = 32'd7;
        @(posedge clk);
        @(negedge clk);
        hi_write = 1'b0; lo_write = 1'b0; hi_select = 2'b00; lo_select = 2'b00;
        repeat (10) @(negedge clk);
        check("step10 busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst mid-div busy", {63'd0, busy}, 64'd0);
        check("rst mid-div hi", {32'd0, hi_out}, 64'd0);
        check("rst mid-div lo", {32'd0, lo_out}, 64'd0);
        rst_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy || hi_out != 32'd0 || lo_out != 32'd0) bad++;
        end
        check("no write after rst", 64'(bad), 64'd0);

        // Random commands against the reference model.
        hi_m = 32'd0;
        lo_m = 32'd0;
        for (int i = 0; i < 40; i++) begin
            logic        hw;
            logic        lw;
            logic [1:0]  hs;
            logic [1:0]  ls;
            logic [31:0] rs;
            logic [31:0] rt;
            int          op;
            int          eb;
            op = $urandom_range(0, 5);
            rs = $urandom;
            rt = $urandom;
            case ($urandom_range(0, 7))
                0: rt = 32'd0;
                1: rt = 32'hFFFF_FFFF;
                2: rs = 32'h8000_0000;
                3: rt = $urandom_range(1, 20);
                default: rs = rs;
            endcase
            case (op)
                0: begin hw = 1'b1; lw = 1'b1; hs = 2'b11; ls = 2'b11; end
                1: begin hw = 1'b1; lw = 1'b1; hs = 2'b10; ls = 2'b10; end
                2: begin hw = 1'b1; lw = 1'b0; hs = 2'b01; ls = 2'b00; end
                3: begin hw = 1'b0; lw = 1'b1; hs = 2'b00; ls = 2'b01; end
                4: begin hw = 1'b1; lw = 1'b1; hs = 2'b01; ls = 2'b01; end
                default: begin
                    hw = 1'($urandom); lw = 1'($urandom);
                    hs = 2'($urandom); ls = 2'($urandom);
                end
            endcase
            model(hw, lw, hs, ls, rs, rt, eb);
            run_op($sformatf("rand%0d", i), hw, lw, hs, ls, rs, rt, hi_m, lo_m, eb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
